// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner for a 12-hour HH MM SS clock.
// Optional build macro COLON_BLINK_EN: colons blink with the seconds LSB.
module clock_display_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       am_pm,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       frame_done,
  output logic       err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_ONE   = 7'b0110000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [3:0] t;
    if (v >= 6'd50)      t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    logic [5:0] r;
    r = v;
    if (r >= 6'd40) r = r - 6'd40;
    if (r >= 6'd20) r = r - 6'd20;
    if (r >= 6'd10) r = r - 6'd10;
    return r[3:0];
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic is_bad(input logic [3:0] h, input logic [5:0] m,
                                  input logic [5:0] s);
    return (h == 4'd0) || (h > 4'd12) || (m > 6'd59) || (s > 6'd59);
  endfunction

  logic [CW-1:0] r_div;
  logic [2:0]    r_idx;
  logic [3:0]    r_h;
  logic [5:0]    r_m;
  logic [5:0]    r_s;
  logic          r_pm;
  logic [6:0]    r_seg;
  logic [5:0]    r_an;
  logic          r_dp;
  logic          r_frame_done;
  logic          r_err;

  logic          w_wrap;
  logic          w_snap;
  logic [2:0]    w_idx_next;
  logic [3:0]    w_h;
  logic [5:0]    w_m;
  logic [5:0]    w_s;
  logic          w_pm;
  logic          w_bad;
  logic [3:0]    w_digit;
  logic          w_colon;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  // Digit 0 of a new frame decodes straight from the inputs being captured.
  always_comb begin
    w_wrap     = (r_div == DIV_LAST);
    w_snap     = w_wrap && (r_idx == 3'd5);
    w_idx_next = w_snap ? 3'd0 : r_idx + 3'd1;
    w_h        = w_snap ? hours   : r_h;
    w_m        = w_snap ? minutes : r_m;
    w_s        = w_snap ? seconds : r_s;
    w_pm       = w_snap ? am_pm   : r_pm;
    w_bad      = w_snap ? is_bad(hours, minutes, seconds) : r_err;

    case (w_idx_next)
      3'd0:    w_digit = (w_h >= 4'd10) ? 4'd1 : 4'd0;
      3'd1:    w_digit = (w_h >= 4'd10) ? w_h - 4'd10 : w_h;
      3'd2:    w_digit = tens_of(w_m);
      3'd3:    w_digit = units_of(w_m);
      3'd4:    w_digit = tens_of(w_s);
      default: w_digit = units_of(w_s);
    endcase

`ifdef COLON_BLINK_EN
    w_colon = ~w_s[0];
`else
    w_colon = 1'b1;
`endif

    if (w_bad)
      w_seg_next = SEG_DASH;
    else if ((w_idx_next == 3'd0) && (w_h < 4'd10))
      w_seg_next = SEG_BLANK;
    else
      w_seg_next = seg_of(w_digit);

    if (w_bad)
      w_dp_next = 1'b0;
    else if ((w_idx_next == 3'd1) || (w_idx_next == 3'd3))
      w_dp_next = w_colon;
    else if (w_idx_next == 3'd5)
      w_dp_next = w_pm;
    else
      w_dp_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_idx        <= 3'd0;
      r_h          <= 4'd12;
      r_m          <= 6'd0;
      r_s          <= 6'd0;
      r_pm         <= 1'b0;
      r_an         <= 6'b000001;
      r_seg        <= SEG_ONE;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= w_snap;
      if (w_wrap) begin
        r_div <= '0;
        r_idx <= w_idx_next;
        r_an  <= 6'b000001 << w_idx_next;
        r_seg <= w_seg_next;
        r_dp  <= w_dp_next;
      end else begin
        r_div <= r_div + CW'(1);
      end
      if (w_snap) begin
        r_h   <= hours;
        r_m   <= minutes;
        r_s   <= seconds;
        r_pm  <= am_pm;
        r_err <= is_bad(hours, minutes, seconds);
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized bench for clock_display_scan against a frame-level reference model.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int FR = 6 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       am_pm;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       frame_done;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;
  int t      = 0;
  int s_h, s_m, s_s, s_p;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  clock_display_scan #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
    .am_pm(am_pm), .seg(seg), .an(an), .dp(dp), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
  endtask

  task automatic check_outputs();
    int idx;
    int dig [6];
    logic bad;
    logic colon;
    logic [6:0] eseg;
    logic edp;
    idx = (t / SD) % 6;
    bad = (s_h < 1) || (s_h > 12) || (s_m > 59) || (s_s > 59);
    dig = '{s_h / 10, s_h % 10, s_m / 10, s_m % 10, s_s / 10, s_s % 10};
`ifdef COLON_BLINK_EN
    colon = (s_s % 2 == 0);
`else
    colon = 1'b1;
`endif
    if (bad) begin
      eseg = 7'b0000001;
      edp  = 1'b0;
    end else begin
      eseg = (idx == 0 && s_h < 10) ? 7'b0000000 : seg_tab[dig[idx]];
      if (idx == 5)                 edp = s_p[0];
      else if (idx == 1 || idx == 3) edp = colon;
      else                          edp = 1'b0;
    end
    chk("an", 32'(an), 32'(1 << idx));
    chk("seg", 32'(seg), 32'(eseg));
    chk("dp", 32'(dp), 32'(edp));
    chk("frame_done", 32'(frame_done), 32'((t > 0) && (t % FR == 0)));
    chk("err", 32'(err), 32'(bad));
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    @(negedge clk);
    if (t > 0 && t % FR == 0) begin
      s_h = int'(hours);
      s_m = int'(minutes);
      s_s = int'(seconds);
      s_p = int'(am_pm);
    end
    check_outputs();
  endtask

  task automatic rnd_inputs();
    hours   = 4'($urandom_range(1, 12));
    minutes = 6'($urandom_range(0, 59));
    seconds = 6'($urandom_range(0, 59));
    am_pm   = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) == 0) begin
      case ($urandom_range(0, 2))
        0:       hours   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(13, 15));
        1:       minutes = 6'($urandom_range(60, 63));
        default: seconds = 6'($urandom_range(60, 63));
      endcase
    end
  endtask

  task automatic model_reset();
    t   = 0;
    s_h = 12;
    s_m = 0;
    s_s = 0;
    s_p = 0;
  endtask

  initial begin
    hours   = 4'd9;
    minutes = 6'd5;
    seconds = 6'd37;
    am_pm   = 1'b1;
    model_reset();
    #7;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();

    repeat (60) step();
    hours = 4'd0;
    repeat (60) step();
    hours = 4'd3;
    repeat (60) step();

    hours = 4'd10; minutes = 6'd59; seconds = 6'd59; am_pm = 1'b0;
    repeat (30) step();
    hours = 4'd11; minutes = 6'd0; seconds = 6'd0;
    repeat (40) step();

    repeat (1500) begin
      step();
      if ($urandom_range(0, 7) == 0) rnd_inputs();
    end

    for (int i = 0; i < 30; i++) begin
      if ((t / SD) % 6 == 3) break;
      step();
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'h01);
    chk("rst_seg", 32'(seg), 32'(7'b0110000));
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs();

    repeat (600) begin
      step();
      if ($urandom_range(0, 7) == 0) rnd_inputs();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the 12-hour timekeeping counter.
- Takes binary hours (1..12), minutes, seconds and the AM/PM flag, and drives a 6-digit multiplexed seven-segment display (HH MM SS).
- Converts each field to BCD, scans one digit at a time, and lights decimal points for the colons and the PM indicator.
- Samples the time once per scan frame so a single frame never mixes old and new values.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays enabled; legal range >= 1; counter width is clog2(SCAN_DIV), minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- hours  input  4  binary hour, legal 1..12
- minutes  input  6  binary minute, legal 0..59
- seconds  input  6  binary second, legal 0..59
- am_pm  input  1  0=AM, 1=PM
- seg  output  7  segments {a,b,c,d,e,f,g}, active-high
- an  output  6  one-hot digit enable, bit0 = leftmost (hours tens), active-high
- dp  output  1  decimal point for the enabled digit, active-high
- frame_done  output  1  one-cycle pulse when a new snapshot is taken
- err  output  1  high for a whole frame whose snapshot was out of range

Behaviour:
- Reset (async, any time, including mid-frame):
  - div_cnt=0, digit_idx=0, snapshot=12:00:00 AM, an=6'b000001, seg=7'b0110000 ('1'), dp=0, frame_done=0, err=0.
- Scan timing:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On a wrap edge, digit_idx advances 0->1->...->5->0.
- Snapshot:
  - Taken on the edge where digit_idx goes 5->0. frame_done=1 for exactly that cycle.
  - Digit 0 of the new frame uses the newly captured values directly, with no extra cycle of latency.
  - Inputs are ignored at all other times.
- Outputs are registered:
  - an, seg and dp update on the same edge as digit_idx.
  - an is always exactly one-hot, matching digit_idx.
- Digit mapping:
  - idx0 = hours tens, idx1 = hours units, idx2 = minutes tens, idx3 = minutes units, idx4 = seconds tens, idx5 = seconds units.
- BCD conversion:
  - tens = value/10, units = value%10.
  - Combinational from the snapshot; no multipliers or dividers beyond constant compare/subtract.
- Leading-zero blank: hours < 10 -> idx0 shows seg=0000000, with an still asserted.
- Segment encoding:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- dp:
  - idx1 and idx3 carry the colon, subject to the optional feature.
  - idx5 = snapshot am_pm.
  - idx0, idx2 and idx4 = 0.
- Invalid snapshot (hours==0, hours>12, minutes>59 or seconds>59):
  - For the whole frame, every digit shows dash 0000001, dp=0 and err=1.
  - err is re-evaluated only at the next snapshot.
- SCAN_DIV=1: the digit advances every cycle and a frame lasts 6 cycles.

Optional Feature:
- Macro: COLON_BLINK_EN.
- Defined: colon dp on idx1/idx3 = 1 only when snapshot seconds[0]==0; 0 on odd seconds.
- Undefined: colon dp on idx1/idx3 is always 1 for valid frames.
- PM dp and error behaviour are identical in both builds.

Test Plan:
- Reset, SCAN_DIV=4:
  - After rst release: an=000001, seg=0110000, dp=0.
  - After 4 clk: an=000010, seg=1101101, dp=1.
  - After 8 clk: an=000100, seg=1111110.
  - First frame_done pulse at cycle 24.
- Hold 9:05:37 PM, SCAN_DIV=4:
  - Next frame shows idx0 blank, then 9, 0, 5, 3, 7.
  - dp=1 on idx5 (PM) and on idx1/idx3 (macro undefined); err=0.
- Tear-free snapshot:
  - Drive 10:59:59 AM at the snapshot, then change to 11:00:00 while idx2 is active.
  - Remainder of the frame shows 5,9,5,9.
  - Next frame shows 1,1,0,0,0,0.
- Invalid input:
  - hours=0 at a snapshot -> all six digits seg=0000001, dp=0, err=1 for 6*SCAN_DIV cycles.
  - Restoring hours=3 clears err at the next frame_done.
- Mid-frame reset:
  - Assert rst while idx3 is enabled -> an=000001 and seg=0110000 immediately (asynchronous), frame_done=0.
  - Scanning restarts from idx0 after release.
- COLON_BLINK_EN defined:
  - Snapshot 12:00:01 -> idx1/idx3 dp=0.
  - Next frame with 12:00:02 -> idx1/idx3 dp=1.
